// File: rtl/sdrd_deser.sv
// Serial read deserializer: assembles SDRD bits into a WIDTH-bit holding
// register with ready/overrun status for the CPU.
module sdrd_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SSER,
  input  logic             BA13,
  input  logic             BA12,
  input  logic             BR_W,
  input  logic             SDRD,
  input  logic             bit_en,
  input  logic             rd_strb,
  output logic [WIDTH-1:0] data_q,
  output logic             rdy,
  output logic             ovr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nx;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_rdy;
  logic             r_ovr;
  logic             r_busy;
  logic             w_sel;
  logic             w_acc;
  logic             w_done;

  assign w_sel  = ~SSER & ~BA13 & BA12 & BR_W;
  assign w_acc  = w_sel & bit_en;
  assign w_done = w_acc && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_shift = r_sr;
    if (MSB_FIRST) w_shift = {r_sr[WIDTH-2:0], SDRD};
    else           w_shift = {SDRD, r_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sr    <= w_sr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_sr_nx    = r_sr;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_state_nx = SHIFT;
          w_cnt_nx   = CW'(1);
          w_sr_nx    = w_shift;
        end
      end
      SHIFT: begin
        // Losing select mid-word or finishing a word both restart from bit 0
        if (!w_sel || w_done) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_sr_nx    = '0;
        end else if (w_acc) begin
          w_cnt_nx = r_cnt + CW'(1);
          w_sr_nx  = w_shift;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_sr_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_rdy  <= 1'b0;
      r_ovr  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == SHIFT);
      if (w_done) begin
        r_data <= w_shift;
        r_rdy  <= 1'b1;
        // A coincident read consumes the old word, so no overrun
        r_ovr  <= r_rdy & ~rd_strb;
      end else if (rd_strb && r_rdy) begin
        r_rdy <= 1'b0;
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_q = r_data;
  assign rdy    = r_rdy;
  assign ovr    = r_ovr;
  assign busy   = r_busy;

endmodule

// File: tb/tb_sdrd_deser.sv
// Bench for sdrd_deser: directed scenarios plus random traffic
// checked against a bit-queue reference model.
module tb_sdrd_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SSER = 1'b1;
  logic       BA13 = 1'b0;
  logic       BA12 = 1'b0;
  logic       BR_W = 1'b0;
  logic       SDRD = 1'b0;
  logic       bit_en = 1'b0;
  logic       rd_strb = 1'b0;
  logic [7:0] dq_m, dq_l;
  logic       rdy_m, ovr_m, busy_m;
  logic       rdy_l, ovr_l, busy_l;

  int checks = 0;
  int errors = 0;

  bit         q[$];
  logic [7:0] e_dm = 8'h00;
  logic [7:0] e_dl = 8'h00;
  logic       e_rdy = 1'b0;
  logic       e_ovr = 1'b0;

  always #5 clk = ~clk;

  sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BR_W(BR_W), .SDRD(SDRD), .bit_en(bit_en), .rd_strb(rd_strb),
    .data_q(dq_m), .rdy(rdy_m), .ovr(ovr_m), .busy(busy_m)
  );

  sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BR_W(BR_W), .SDRD(SDRD), .bit_en(bit_en), .rd_strb(rd_strb),
    .data_q(dq_l), .rdy(rdy_l), .ovr(ovr_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit sel;
    bit done;
    sel  = !SSER && !BA13 && BA12 && BR_W;
    done = 0;
    if (rst) begin
      q.delete();
      e_dm = 0; e_dl = 0; e_rdy = 0; e_ovr = 0;
      return;
    end
    if (!sel) q.delete();
    else if (bit_en) q.push_back(SDRD);
    if (q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        e_dm[7-i] = q[i];
        e_dl[i]   = q[i];
      end
      q.delete();
      done = 1;
    end
    if (done) begin
      e_ovr = e_rdy && !rd_strb;
      e_rdy = 1;
    end else if (rd_strb && e_rdy) begin
      e_rdy = 0;
      e_ovr = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("data_m", 32'(dq_m), 32'(e_dm));
    chk("data_l", 32'(dq_l), 32'(e_dl));
    chk("rdy_m", 32'(rdy_m), 32'(e_rdy));
    chk("rdy_l", 32'(rdy_l), 32'(e_rdy));
    chk("ovr_m", 32'(ovr_m), 32'(e_ovr));
    chk("ovr_l", 32'(ovr_l), 32'(e_ovr));
    chk("busy_m", 32'(busy_m), 32'(q.size() != 0));
    chk("busy_l", 32'(busy_l), 32'(q.size() != 0));
  endtask

  task automatic sel_on();
    SSER = 0; BA13 = 0; BA12 = 1; BR_W = 1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n,
                           input bit rd_last);
    for (int i = 0; i < n; i++) begin
      SDRD    = w[7-i];
      bit_en  = 1;
      rd_strb = rd_last && (i == n - 1);
      step();
    end
    bit_en  = 0;
    rd_strb = 0;
  endtask

  task automatic do_read();
    rd_strb = 1;
    step();
    rd_strb = 0;
  endtask

  initial begin
    rst = 1;
    step();
    chk("rst_data", 32'(dq_m), 32'h0);
    chk("rst_rdy", 32'(rdy_m), 32'h0);
    rst = 0;
    sel_on();
    step();

    send_bits(8'hA5, 8, 0);
    chk("a5_m", 32'(dq_m), 32'hA5);
    chk("a5_l", 32'(dq_l), 32'hA5);
    chk("a5_rdy", 32'(rdy_m), 32'h1);
    chk("a5_busy", 32'(busy_m), 32'h0);
    do_read();

    send_bits(8'hC0, 8, 0);
    chk("c0_m", 32'(dq_m), 32'hC0);
    chk("c0_l", 32'(dq_l), 32'h03);
    do_read();

    send_bits(8'hB0, 4, 0);
    chk("part_busy", 32'(busy_m), 32'h1);
    SSER = 1;
    step();
    chk("abort_busy", 32'(busy_m), 32'h0);
    SSER = 0;
    send_bits(8'hFF, 8, 0);
    chk("ff_m", 32'(dq_m), 32'hFF);
    chk("ff_l", 32'(dq_l), 32'hFF);
    do_read();

    send_bits(8'h12, 8, 0);
    send_bits(8'h34, 8, 0);
    chk("ovr_data", 32'(dq_m), 32'h34);
    chk("ovr_rdy", 32'(rdy_m), 32'h1);
    chk("ovr_set", 32'(ovr_m), 32'h1);
    do_read();
    chk("rd_rdy", 32'(rdy_m), 32'h0);
    chk("rd_ovr", 32'(ovr_m), 32'h0);
    chk("rd_hold", 32'(dq_m), 32'h34);

    send_bits(8'h12, 8, 0);
    send_bits(8'h56, 8, 1);
    chk("co_data", 32'(dq_m), 32'h56);
    chk("co_rdy", 32'(rdy_m), 32'h1);
    chk("co_ovr", 32'(ovr_m), 32'h0);

    send_bits(8'hF8, 5, 0);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_data", 32'(dq_m), 32'h0);
    chk("mrst_busy", 32'(busy_m), 32'h0);
    send_bits(8'h81, 8, 0);
    chk("81_m", 32'(dq_m), 32'h81);
    chk("81_l", 32'(dq_l), 32'h81);

    for (int n = 0; n < 4000; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      SSER    = ($urandom_range(0, 19) == 0);
      BA13    = ($urandom_range(0, 29) == 0);
      BA12    = ($urandom_range(0, 29) != 0);
      BR_W    = ($urandom_range(0, 29) != 0);
      SDRD    = 1'($urandom);
      bit_en  = ($urandom_range(0, 2) != 0);
      rd_strb = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrd_deser.md
SDRD_DESER -- requirements
Module: sdrd_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of serial bits per assembled word (legal 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in data_q[WIDTH-1], 0 = first bit lands in data_q[0].
REQ-003 SHALL have port clk  input  1  single rising-edge clock shared with the serial read sequencer.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SSER  input  1  serial select, active-low.
REQ-006 SHALL have port BA13, BA12  input  1 each  bus address decode bits.
REQ-007 SHALL have port BR_W  input  1  bus read/write, 1 = read.
REQ-008 SHALL have port SDRD  input  1  serial data bit from the read sequencer.
REQ-009 SHALL have port bit_en  input  1  one-cycle strobe marking SDRD valid this cycle.
REQ-010 SHALL have port rd_strb  input  1  one-cycle CPU read of the holding register.
REQ-011 SHALL have port data_q  output  WIDTH  holding register, last complete word.
REQ-012 SHALL have port rdy  output  1  holding register contains an unread word.
REQ-013 SHALL have port ovr  output  1  a complete word overwrote an unread word.
REQ-014 SHALL have port busy  output  1  partial word in progress.

Function
REQ-015 SHALL derive sel = ~SSER & ~BA13 & BA12 & BR_W, combinationally, each cycle.
REQ-016 SHALL implement a two-state FSM: IDLE (bit count 0) and SHIFT (count 1..WIDTH-1); busy = (state == SHIFT).
REQ-017 SHALL accept a bit only in a cycle with sel=1 and bit_en=1; all other cycles leave shift register and count unchanged except per REQ-021.
REQ-018 SHALL, on accepted bit, shift SDRD into the shift register per MSB_FIRST and increment the count; IDLE->SHIFT on the first bit.
REQ-019 SHALL, on the WIDTH-th accepted bit, load the completed word (including that bit) into data_q at that same clock edge, set rdy=1, clear count to 0 and return to IDLE; latency from final bit_en to rdy = 1 cycle.
REQ-020 SHALL keep count width ceil(log2(WIDTH+1)) bits; count never exceeds WIDTH-1 in SHIFT and never wraps.
REQ-021 SHALL, if sel=0 in any cycle while in SHIFT, discard the partial word, clear count and go to IDLE; data_q, rdy, ovr unaffected.
REQ-022 SHALL, on rd_strb=1, clear rdy and ovr at the next edge; data_q holds its value.
REQ-023 SHALL, on word completion with rdy=1 and rd_strb=0, overwrite data_q, keep rdy=1, set ovr=1.
REQ-024 SHALL, on word completion and rd_strb in the same cycle, load the new word, leave rdy=1, and clear ovr (the read consumed the old word).
REQ-025 SHALL ignore rd_strb when rdy=0 (no state change).
REQ-026 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set state IDLE, count 0, shift register 0, data_q 0, rdy 0, ovr 0, busy 0, overriding all other inputs that cycle.
REQ-028 SHALL, on rst asserted mid-word, discard the partial word; the first accepted bit after rst deasserts is bit 0 of a new word.

Verification
REQ-029 SHALL cover: WIDTH=8, MSB_FIRST=1, sel=1, bits 1,0,1,0,0,1,0,1 on bit_en -> data_q=0xA5, rdy=1 one cycle after 8th strobe, busy=0.
REQ-030 SHALL cover: MSB_FIRST=0, same bit sequence -> data_q=0xA5 reversed = 0xA5 bit-swapped = 0xA5? use 1,1,0,0,0,0,0,0 -> data_q=0x03.
REQ-031 SHALL cover: 4 bits accepted, SSER=1 for one cycle, then 8 bits 0xFF -> data_q=0xFF, no trace of partial bits.
REQ-032 SHALL cover: word 0x12 completed, not read, word 0x34 completed -> data_q=0x34, rdy=1, ovr=1; rd_strb -> rdy=0, ovr=0 next cycle.
REQ-033 SHALL cover: rdy=1 with 0x12, rd_strb coincident with completion of 0x56 -> data_q=0x56, rdy=1, ovr=0.
REQ-034 SHALL cover: rst pulsed after 5 accepted bits -> all outputs 0 next cycle; following 8 bits 0x81 -> data_q=0x81.
